// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-to-1 stream multiplexer with fixed or round-robin select and one output register stage
// Optional transfer counter on output xfer_count is built when STREAM_MUX_XFER_CNT_EN is defined.
module stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
`ifdef STREAM_MUX_XFER_CNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] next_ptr;
  logic [WIDTH-1:0] sel_data;
  logic             any_grant;
  logic             can_load;
  logic             ld;

  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    cand      = '0;
    sum       = '0;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i)) begin
          grant_idx = SEL_W'(i);
          any_grant = in_valid[i];
        end
      end
    end else begin
      // Walk offsets high to low so the channel closest to rr_ptr wins last.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (sum >= (SEL_W+1)'(NUM_IN)) sum = sum - (SEL_W+1)'(NUM_IN);
        cand = sum[SEL_W-1:0];
        if (in_valid[cand]) begin
          any_grant = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_load = !out_valid || out_ready;
  assign ld       = can_load && any_grant;
  assign in_ready = (RESET_N && ld) ? (NUM_IN'(1) << grant_idx) : '0;
  assign next_ptr = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant_idx;
        if (mode) rr_ptr <= next_ptr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_XFER_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready && xfer_count != 16'hFFFF) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - table-driven bench for stream_mux with a data/channel scoreboard
module tb_stream_mux;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [S-1:0]   sel = '0;
  logic           mode = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [S-1:0]   out_chan;
`ifdef STREAM_MUX_XFER_CNT_EN
  logic [15:0]    xfer_count;
`endif

  stream_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan (out_chan)
`ifdef STREAM_MUX_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         m;
    logic [S-1:0] s;
    logic [N-1:0] iv;
    logic         ord;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic [S-1:0] c;
  } word_t;

  vec_t  vecs[25];
  word_t sb[$];
  int    tests = 0;
  int    fails = 0;
  int    model_xfers = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input logic m, input logic [S-1:0] s, input logic [N-1:0] iv,
                       input logic ord, input logic [N-1:0] exp_rdy, input logic exp_ov,
                       input logic [31:0] dat, input string name);
    word_t w;
    mode = m; sel = s; in_valid = iv; out_ready = ord; in_data = dat;
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    check({name, " onehot"}, 32'($countones(in_ready) <= 1), 32'd1);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check({name, " sb_empty"}, 32'd1, 32'd0);
      end else begin
        check({name, " out_data"}, 32'(out_data), 32'(sb[0].d));
        check({name, " out_chan"}, 32'(out_chan), 32'(sb[0].c));
        if (out_ready) begin
          void'(sb.pop_front());
          model_xfers++;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (in_ready[k] && in_valid[k]) begin
        w.d = in_data[k*W +: W];
        w.c = S'(k);
        sb.push_back(w);
      end
    end
    @(posedge CLK);
    #1;
    check({name, " out_valid"}, 32'(out_valid), 32'(exp_ov));
    @(negedge CLK);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1};
    vecs[1]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 2'd1, 4'b0100, 1'b1, 4'b0000, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b1000, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1};
    vecs[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1};
    vecs[14] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1};
    vecs[15] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1};
    vecs[16] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1};
    vecs[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[18] = '{1'b1, 2'd0, 4'b0110, 1'b0, 4'b0010, 1'b1};
    vecs[19] = '{1'b1, 2'd0, 4'b0110, 1'b0, 4'b0000, 1'b1};
    vecs[20] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, 1'b1};
    vecs[21] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1};
    vecs[22] = '{1'b0, 2'd2, 4'b0110, 1'b1, 4'b0100, 1'b1};
    vecs[23] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
    vecs[24] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0};

    mode = 1'b0; in_valid = 4'b1111;
    repeat (2) @(negedge CLK);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_chan", 32'(out_chan), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    in_valid = '0;
    RESET_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 25; i++) begin
      apply(vecs[i].m, vecs[i].s, vecs[i].iv, vecs[i].ord, vecs[i].exp_rdy, vecs[i].exp_ov,
            (i == 0) ? 32'h00A1_0000 : $urandom, $sformatf("v%0d", i));
      if (i == 0) begin
        check("v0 data A1", 32'(out_data), 32'hA1);
        check("v0 chan 2", 32'(out_chan), 32'd2);
      end
    end

`ifdef STREAM_MUX_XFER_CNT_EN
    check("xfer_count", 32'(xfer_count), 32'(model_xfers));
`endif

    // Pointer is 3 here: ch1 is granted and the word is held with out_ready low.
    apply(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0010, 1'b1, $urandom, "pre_rst");
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'd0);
    check("async out_data", 32'(out_data), 32'd0);
    check("async out_chan", 32'(out_chan), 32'd0);
    check("async in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    model_xfers = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    apply(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, $urandom, "post_rst0");
    apply(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, $urandom, "post_rst1");
    apply(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, $urandom, "drain");

`ifdef STREAM_MUX_XFER_CNT_EN
    check("xfer_count post", 32'(xfer_count), 32'(model_xfers));
`endif
    check("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits, >=1.
REQ-002 Parameter NUM_IN, default 4, number of input channels, 2..16.
REQ-003 Parameter SEL_W, default 2, select width; SHALL equal ceil(log2(NUM_IN)).
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 in_data  input  NUM_IN*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel data-valid.
REQ-008 in_ready  output  NUM_IN  per-channel accept; a transfer on channel i is in_valid[i] && in_ready[i] at a rising edge.
REQ-009 sel  input  SEL_W  channel index used in fixed mode.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accept; output transfer = out_valid && out_ready.
REQ-014 out_chan  output  SEL_W  registered index of the channel that supplied out_data.

Function
REQ-015 Single output register stage; load enable ld = (!out_valid || out_ready) && any grant.
REQ-016 Fixed mode: grant channel sel iff in_valid[sel]; sel >= NUM_IN grants nothing.
REQ-017 Round-robin mode: search from pointer rr_ptr upward with wrap-around; grant first channel with in_valid set.
REQ-018 At most one in_ready bit high per cycle; in_ready[i] = grant[i] && (!out_valid || out_ready).
REQ-019 in_ready SHALL NOT depend on in_data; combinational dependence on in_valid, sel, mode, out_valid, out_ready is permitted.
REQ-020 On ld: out_data <= granted channel data, out_chan <= granted index, out_valid <= 1; latency input transfer -> out_valid = 1 cycle.
REQ-021 Output transfer without ld: out_valid <= 0; simultaneous output transfer and ld: out_valid stays 1, new word replaces old (full throughput, one word/cycle).
REQ-022 out_valid && !out_ready: out_data, out_chan, out_valid held; all in_ready low.
REQ-023 rr_ptr updates only on an input transfer in round-robin mode: rr_ptr <= (granted+1) mod NUM_IN, wrapping NUM_IN-1 -> 0.
REQ-024 Fixed-mode transfers leave rr_ptr unchanged.
REQ-025 mode or sel changes take effect on the same cycle's grant; a word already in the output register is unaffected.
REQ-026 No in_valid set: no grant, all in_ready low, rr_ptr unchanged.

Reset
REQ-027 RESET_N low asynchronously forces out_valid=0, out_data=0, out_chan=0, rr_ptr=0, (xfer_count=0 if built); in_ready low during reset.
REQ-028 Reset mid-transfer discards the held word; first grant after release uses rr_ptr=0.

Configuration
REQ-029 Macro STREAM_MUX_XFER_CNT_EN defined: add output xfer_count (16 bits), incremented on each output transfer, saturating at 16'hFFFF.
REQ-030 Macro undefined: port xfer_count and counter absent; all other behaviour identical.

Verification
REQ-031 Fixed mode, sel=2, in_valid=4'b0100, ch2 data 8'hA1, out_ready=1 -> next cycle out_data=8'hA1, out_chan=2, out_valid=1.
REQ-032 Round-robin, all in_valid=1, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1; one word per cycle.
REQ-033 out_ready=0 with out_valid=1 for 3 cycles, ch data changing -> out_data held, in_ready=4'b0000; out_ready=1 -> next word loaded same edge.
REQ-034 Round-robin, in_valid=4'b1001 after ptr=1 -> grant ch3, then ptr wraps to 0 -> grant ch0.
REQ-035 Assert RESET_N=0 asynchronously while out_valid=1 -> out_valid=0 immediately, out_data=8'h00; after release first grant from ch0.
REQ-036 With STREAM_MUX_XFER_CNT_EN, 5 output transfers -> xfer_count=5; preset near saturation -> stays 16'hFFFF.
